// File: rtl/axi4lite_gpio_master_if.sv
// AXI4-Lite bus bundle between the GPIO command master and the GPIO register slave.
interface axi4lite_gpio_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_gpio_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into one AXI write
// (AW+W+B) or read (AR+R), returns the response, then accepts the next command.
// All outputs come straight from flops, so no ready input reaches any valid output.
module axi4lite_gpio_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic                timeout_err,
  axi4lite_gpio_master_if.master m_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  TMO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_D = 3'd4,
    ST_RSP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                aw_pending, w_pending, waiting;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_pending  = 1'b0;
    w_pending   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr & ALIGN_MASK;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_A;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        // AW and W complete independently; each valid drops after its own handshake.
        aw_pending = awvalid_q && !m_axi.awready;
        w_pending  = wvalid_q && !m_axi.wready;
        awvalid_d  = aw_pending;
        wvalid_d   = w_pending;
        if (!aw_pending && !w_pending) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end else begin
          state_d  = ST_WR;
        end
      end
      ST_WR_B: begin
        if (m_axi.bvalid && bready_q) begin
          state_d     = ST_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
        end else begin
          state_d = ST_WR_B;
        end
      end
      ST_RD_A: begin
        if (arvalid_q && m_axi.arready) begin
          state_d   = ST_RD_D;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_D: begin
        if (m_axi.rvalid && rready_q) begin
          state_d     = ST_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
        end else begin
          state_d = ST_RD_D;
        end
      end
      ST_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Per-channel wait counter; it only flags, the transaction keeps running.
  always_comb begin
    waiting = (state_q == ST_WR) || (state_q == ST_WR_B) ||
              (state_q == ST_RD_A) || (state_q == ST_RD_D);
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (waiting && (tmo_cnt_q != TMO_LIMIT)) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    timeout_err_d = timeout_err_q ||
                    ((TIMEOUT_CYCLES != 0) && waiting && (tmo_cnt_d == TMO_LIMIT));
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign timeout_err   = timeout_err_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4lite_gpio_master.sv
// Bench for axi4lite_gpio_master: a behavioural AXI4-Lite slave with its own
// register array, and a word-array reference model predicting responses from
// the issued commands alone.
module tb_axi4lite_gpio_master;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = 9'h000;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        timeout_err;

  axi4lite_gpio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

  axi4lite_gpio_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err),
    .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem   [0:127];
  logic [31:0] slave_mem [0:127];
  logic        err_at_ar [1:40];
  bit          exp_tmo = 1'b0;
  bit          r_wr;
  logic [8:0]  r_addr;
  logic [1:0]  r_resp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command through the DUT with the slave inserting the given ready/valid delays.
  task automatic run_txn(input bit wr, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int aw_dly, input int w_dly,
                         input int b_dly, input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input int rsp_dly);
    logic [8:0]  exp_addr;
    logic [31:0] exp_rdata;
    int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0, rsp_cnt = 0;
    int b_hs = 0, r_hs = 0, cyc = 0;
    bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0, rsp_done = 0;
    bit aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0, rsp_pend = 0;
    bit proto_ok = 1, stable_ok = 1, busy_ok = 1, tmo_ok = 1, committed = 0;
    logic [8:0]  aw_a = 9'h0, ar_a = 9'h0;
    logic [31:0] w_d = 32'h0, rsp_d0 = 32'h0;
    logic [3:0]  w_s = 4'h0;
    logic        rsp_w0 = 1'b0;
    logic [1:0]  rsp_r0 = 2'b00;

    exp_addr  = {addr[8:2], 2'b00};
    exp_rdata = wr ? 32'h0 : ref_mem[addr[8:2]];

    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = 9'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    if (wr) chk("wr_issue_latency", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 3'b110);
    else    chk("rd_issue_latency", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 3'b001);

    while (!rsp_done && cyc < 300) begin
      if (aw_pend) aw_done = 1;
      if (w_pend)  w_done = 1;
      if (b_pend)  begin b_done = 1; b_hs++; m_axi.bvalid = 1'b0; end
      if (ar_pend) ar_done = 1;
      if (r_pend)  begin r_done = 1; r_hs++; m_axi.rvalid = 1'b0; end
      if (rsp_pend) begin rsp_done = 1; rsp_ready = 1'b0; end
      aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0; rsp_pend = 0;
      if (!rsp_done) begin
        if (m_axi.awvalid) begin
          if (!wr || aw_done) proto_ok = 0;
          if (aw_seen == 0) aw_a = m_axi.awaddr;
          else if (m_axi.awaddr !== aw_a) stable_ok = 0;
          aw_seen++;
        end else if (wr && !aw_done) proto_ok = 0;
        m_axi.awready = m_axi.awvalid && (aw_seen > aw_dly);
        aw_pend = m_axi.awvalid && m_axi.awready;

        if (m_axi.wvalid) begin
          if (!wr || w_done) proto_ok = 0;
          if (w_seen == 0) begin w_d = m_axi.wdata; w_s = m_axi.wstrb; end
          else if (m_axi.wdata !== w_d || m_axi.wstrb !== w_s) stable_ok = 0;
          w_seen++;
        end else if (wr && !w_done) proto_ok = 0;
        m_axi.wready = m_axi.wvalid && (w_seen > w_dly);
        w_pend = m_axi.wvalid && m_axi.wready;

        if (wr && aw_done && w_done && !committed) begin
          for (int i = 0; i < 4; i++)
            if (w_s[i]) slave_mem[aw_a[8:2]][8*i +: 8] = w_d[8*i +: 8];
          committed = 1;
        end
        if (wr && aw_done && w_done && !b_done) begin
          b_cnt++;
          if (b_cnt > b_dly) begin m_axi.bvalid = 1'b1; m_axi.bresp = resp; end
        end
        if (b_done && m_axi.bready) proto_ok = 0;
        b_pend = m_axi.bvalid && m_axi.bready;

        if (m_axi.arvalid) begin
          if (wr || ar_done) proto_ok = 0;
          if (ar_seen == 0) ar_a = m_axi.araddr;
          else if (m_axi.araddr !== ar_a) stable_ok = 0;
          ar_seen++;
          if (ar_seen <= 40) err_at_ar[ar_seen] = timeout_err;
        end else if (!wr && !ar_done) proto_ok = 0;
        m_axi.arready = m_axi.arvalid && (ar_seen > ar_dly);
        ar_pend = m_axi.arvalid && m_axi.arready;

        if (!wr && ar_done && !r_done) begin
          r_cnt++;
          if (r_cnt > r_dly) begin
            m_axi.rvalid = 1'b1; m_axi.rdata = slave_mem[ar_a[8:2]]; m_axi.rresp = resp;
          end
        end
        if (r_done && m_axi.rready) proto_ok = 0;
        if (wr && m_axi.rready) proto_ok = 0;
        if (!wr && m_axi.bready) proto_ok = 0;
        r_pend = m_axi.rvalid && m_axi.rready;

        if (rsp_valid) begin
          if (rsp_cnt == 0) begin rsp_w0 = rsp_write; rsp_d0 = rsp_rdata; rsp_r0 = rsp_resp; end
          else if (rsp_write !== rsp_w0 || rsp_rdata !== rsp_d0 || rsp_resp !== rsp_r0) stable_ok = 0;
          rsp_cnt++;
          rsp_ready = (rsp_cnt > rsp_dly);
        end
        rsp_pend = rsp_valid && rsp_ready;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_ok = 0;
        if (!exp_tmo && timeout_err !== 1'b0) tmo_ok = 0;
        @(negedge clk);
        cyc++;
      end
    end

    chk("txn_done", rsp_done, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("rsp_write", rsp_w0, wr);
    chk("rsp_resp", rsp_r0, resp);
    chk("rsp_rdata", rsp_d0, exp_rdata);
    chk("rsp_seen_cycles", rsp_cnt, rsp_dly + 1);
    chk("protocol", proto_ok, 1);
    chk("payload_stable", stable_ok, 1);
    chk("busy_during_txn", busy_ok, 1);
    chk("timeout_quiet", tmo_ok, 1);
    if (wr) begin
      chk("aw_valid_cycles", aw_seen, aw_dly + 1);
      chk("w_valid_cycles", w_seen, w_dly + 1);
      chk("awaddr", aw_a, exp_addr);
      chk("wdata", w_d, wdata);
      chk("wstrb", w_s, wstrb);
      chk("b_handshakes", b_hs, 1);
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) ref_mem[addr[8:2]][8*i +: 8] = wdata[8*i +: 8];
    end else begin
      chk("ar_valid_cycles", ar_seen, ar_dly + 1);
      chk("araddr", ar_a, exp_addr);
      chk("r_handshakes", r_hs, 1);
    end
  endtask

  initial begin
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0; m_axi.rresp = 2'b00;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = $urandom;
      slave_mem[i] = ref_mem[i];
    end

    // Reset state
    #3;
    chk("reset_ctrl", {cmd_ready, rsp_valid, busy, timeout_err, rsp_write}, 5'b0);
    chk("reset_axi_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 5'b0);
    chk("reset_payload", {m_axi.awaddr, m_axi.wdata, m_axi.wstrb, m_axi.araddr}, 0);
    chk("reset_rsp_data", {rsp_rdata, rsp_resp}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("cmd_ready_at_release", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_first_clock", cmd_ready, 1);

    // Directed cases
    run_txn(1'b1, 9'h004, 32'h0000_0000, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b1, 9'h000, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b0, 9'h000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("readback_a5a5", ref_mem[0], 32'hA5A5_0F0F);
    run_txn(1'b1, 9'h00C, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 0, 2'b00, 2);
    run_txn(1'b1, 9'h00C, 32'hFFFF_FFFF, 4'h0, 0, 2, 1, 0, 0, 2'b00, 0);
    run_txn(1'b0, 9'h00C, 32'h0,         4'h0, 0, 0, 0, 1, 2, 2'b00, 0);
    run_txn(1'b1, 9'h010, 32'hCAFE_F00D, 4'h5, 1, 1, 3, 0, 0, 2'b11, 1);
    run_txn(1'b0, 9'h1FF, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b10, 0);

    // Randomized traffic over a small address window so reads hit prior writes
    for (int n = 0; n < 24; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 9'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      r_resp = r_wr ? 2'b00 : 2'($urandom_range(0, 3));
      run_txn(r_wr, r_addr, $urandom, 4'($urandom),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom_range(0, 5), r_resp, $urandom_range(0, 4));
    end

    // Timeout: arready withheld for 20 cycles, read still completes
    exp_tmo = 1'b1;
    run_txn(1'b0, 9'h008, 32'h0, 4'h0, 0, 0, 0, 20, 0, 2'b00, 0);
    chk("tmo_before_limit", err_at_ar[16], 0);
    chk("tmo_at_limit", err_at_ar[17], 1);
    chk("tmo_arvalid_held", err_at_ar[21], 1);
    chk("tmo_sticky", timeout_err, 1);

    // Reset in WR_B with the response never consumed
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h0F0; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_aw_w", {m_axi.awvalid, m_axi.wvalid}, 2'b11);
    m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    @(negedge clk);
    m_axi.awready = 1'b0; m_axi.wready = 1'b0;
    chk("rst_in_wr_b", {m_axi.bready, busy, rsp_valid}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {m_axi.bready, rsp_valid, busy, cmd_ready, timeout_err}, 5'b0);
    chk("rst_async_axi", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.rready, m_axi.awaddr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("rst_cmd_ready_after", cmd_ready, 1);
    chk("rst_timeout_cleared", timeout_err, 0);
    exp_tmo = 1'b0;

    // Recovery after reset
    run_txn(1'b0, 9'h000, 32'h0, 4'h0, 1, 0, 0, 1, 1, 2'b00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4lite_gpio_master.md
Name: axi4lite_gpio_master

Overview:
- AXI4-Lite initiator that drives the AXI GPIO register slave from a simple single-beat command/response port.
- Converts one command into one AXI4-Lite write (AW+W+B) or read (AR+R), returns the response, then accepts the next command.
- Sits between test/firmware-model logic and the GPIO slave's s_axi_* port. One outstanding transaction at a time.

Parameters:
- ADDR_W, 9, AXI address width (matches slave awaddr/araddr).
- DATA_W, 32, AXI data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, cycles waiting on any single channel handshake before timeout_err is flagged; 0 disables.

Ports:
- s_axi_aclk  in  1  clock, all logic rising-edge.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  BRESP or RRESP as returned.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky, cleared only by reset.
- m_axi_awaddr  out  ADDR_W; m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  DATA_W; m_axi_wstrb  out  DATA_W/8; m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- m_axi_araddr  out  ADDR_W; m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1.

Behaviour:
- Reset (async assert, sync release):
  - All valid/ready outputs 0; rsp_* 0; addr/data/strb outputs 0.
  - busy=0; timeout_err=0; state=IDLE; timeout counter 0.
  - cmd_ready=1 from the first clock after reset release.
- States: IDLE, WR (AW/W pending), WR_B, RD_A, RD_D, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, register addr with bits[1:0] forced to 0, plus wdata and wstrb.
  - Next state is WR if cmd_write else RD_A.
  - AW/W/AR valid is asserted on the cycle after accept (1-cycle latency).
- WR:
  - awvalid and wvalid assert together.
  - Each drops independently the cycle after its own handshake; awready and wready may arrive in either order or the same cycle.
  - When both are done: go to WR_B with bready=1.
- WR_B:
  - On bvalid&&bready, capture bresp; rsp_write=1; rsp_rdata=0; go to RSP.
  - bready drops the next cycle.
- RD_A:
  - arvalid=1 until arready, then go to RD_D with rready=1.
- RD_D:
  - On rvalid&&rready, capture rdata/rresp; rsp_write=0; go to RSP.
- RSP:
  - rsp_valid=1 and held stable until rsp_ready; the cycle after, go to IDLE.
  - No new command in RSP (cmd_ready=0), so back-to-back issue is ≥1 idle cycle apart.
- AXI rules:
  - Once asserted, valid and its payload hold stable until handshake; no combinational path from any ready to any valid.
  - wstrb=0 is passed through unchanged.
  - SLVERR/DECERR are reported in rsp_resp, not retried.
- Timeout:
  - Counter resets on every state change and counts cycles spent in WR, WR_B, RD_A or RD_D.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets (sticky).
  - The transaction is NOT abandoned; valids stay asserted, keeping the bus protocol-legal.
- Reset mid-transaction: all outputs return to reset values immediately on aresetn low; any in-flight transaction is lost with no response.
- Reads of the same address immediately after a write are ordered: the read is not issued until the B response of the write is consumed.

Test Plan:
- Write cmd addr=0x004, wdata=0x0000_0000, wstrb=0xF; slave readies immediately -> awvalid/wvalid high 1 cycle after accept; rsp_valid with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Write addr=0x000, wdata=0xA5A5_0F0F, then read addr=0x000 -> araddr=0x000 after the write's rsp consumed; rsp_rdata=0xA5A5_0F0F, rsp_resp=00.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr; exactly one B handshake.
- Read addr=0x1FF (unaligned), slave returns rresp=10 -> m_axi_araddr=0x1FC; rsp_resp=10.
- TIMEOUT_CYCLES=16, arready held low 20 cycles -> timeout_err=1 at cycle 16, arvalid still 1; read completes normally when arready arrives.
- Reset asserted while in WR_B with rsp_ready low -> bready, rsp_valid and busy go 0 immediately; cmd_ready=1 one clock after release; timeout_err=0.
